// File: rtl/dsc_pkg.sv
// Shared types and defaults for the DSC slice scheduler.
package dsc_pkg;

    localparam int DIM_W_DEF       = 13;
    localparam int TIMEOUT_CYC_DEF = 65535;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/dsc_slice_walker.sv
// Raster walker: latched frame geometry, current slice origin and the
// registered clipped size / last flag of the descriptor being offered.
module dsc_slice_walker
    import dsc_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [DIM_W-1:0] cfg_pic_w,
    input  logic [DIM_W-1:0] cfg_pic_h,
    input  logic [DIM_W-1:0] cfg_slice_w,
    input  logic [DIM_W-1:0] cfg_slice_h,
    output logic [DIM_W-1:0] slc_x,
    output logic [DIM_W-1:0] slc_y,
    output logic [DIM_W-1:0] slc_w,
    output logic [DIM_W-1:0] slc_h,
    output logic             slc_last
);

    logic [DIM_W-1:0] pic_w_q, pic_h_q, slice_w_q, slice_h_q;
    logic [DIM_W-1:0] pic_w_d, pic_h_d, slice_w_d, slice_h_d;
    logic [DIM_W-1:0] x_q, y_q, w_q, h_q;
    logic [DIM_W-1:0] x_d, y_d, w_d, h_d;
    logic             last_q, last_d;
    logic [DIM_W:0]   rem_w, rem_h;
    logic             row_end;

    assign row_end = ({1'b0, x_q} + {1'b0, slice_w_q}) >= {1'b0, pic_w_q};

    // Size and last are derived from the next origin so they land in the
    // same cycle as the origin they describe.
    always_comb begin
        pic_w_d   = pic_w_q;
        pic_h_d   = pic_h_q;
        slice_w_d = slice_w_q;
        slice_h_d = slice_h_q;
        x_d       = x_q;
        y_d       = y_q;
        if (load) begin
            pic_w_d   = cfg_pic_w;
            pic_h_d   = cfg_pic_h;
            slice_w_d = cfg_slice_w;
            slice_h_d = cfg_slice_h;
            x_d       = '0;
            y_d       = '0;
        end else if (advance) begin
            if (row_end) begin
                x_d = '0;
                y_d = y_q + slice_h_q;
            end else begin
                x_d = x_q + slice_w_q;
            end
        end
        rem_w  = {1'b0, pic_w_d} - {1'b0, x_d};
        rem_h  = {1'b0, pic_h_d} - {1'b0, y_d};
        w_d    = ({1'b0, slice_w_d} < rem_w) ? slice_w_d : rem_w[DIM_W-1:0];
        h_d    = ({1'b0, slice_h_d} < rem_h) ? slice_h_d : rem_h[DIM_W-1:0];
        last_d = (({1'b0, x_d} + {1'b0, slice_w_d}) >= {1'b0, pic_w_d}) &&
                 (({1'b0, y_d} + {1'b0, slice_h_d}) >= {1'b0, pic_h_d});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pic_w_q   <= '0;
            pic_h_q   <= '0;
            slice_w_q <= '0;
            slice_h_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            last_q    <= 1'b0;
        end else begin
            pic_w_q   <= pic_w_d;
            pic_h_q   <= pic_h_d;
            slice_w_q <= slice_w_d;
            slice_h_q <= slice_h_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            last_q    <= last_d;
        end
    end

    assign slc_x    = x_q;
    assign slc_y    = y_q;
    assign slc_w    = w_q;
    assign slc_h    = h_q;
    assign slc_last = last_q;

endmodule

// File: rtl/dsc_slice_scheduler.sv
// Frame-level slice scheduler FSM: issues raster-ordered slice descriptors.
// Optional WAIT watchdog is enabled by defining DSC_SLICE_TIMEOUT_EN.
module dsc_slice_scheduler
    import dsc_pkg::*;
#(
    parameter int DIM_W       = DIM_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIM_W-1:0] cfg_pic_w,
    input  logic [DIM_W-1:0] cfg_pic_h,
    input  logic [DIM_W-1:0] cfg_slice_w,
    input  logic [DIM_W-1:0] cfg_slice_h,
    input  logic             abort,
    output logic             slc_valid,
    input  logic             slc_ready,
    output logic [DIM_W-1:0] slc_x,
    output logic [DIM_W-1:0] slc_y,
    output logic [DIM_W-1:0] slc_w,
    output logic [DIM_W-1:0] slc_h,
    output logic             slc_last,
    input  logic             slc_done,
    output logic             frm_done,
    output logic             err,
    output logic             busy
);

    sched_state_e state_q, state_d;
    logic load, advance, cfg_ok, timeout_hit;
    logic slc_valid_d, cfg_ready_d, frm_done_d, err_d, busy_d;
    logic slc_valid_q, cfg_ready_q, frm_done_q, err_q, busy_q;

    assign cfg_ok = (|cfg_pic_w) && (|cfg_pic_h) && (|cfg_slice_w) && (|cfg_slice_h) &&
                    (cfg_slice_w <= cfg_pic_w) && (cfg_slice_h <= cfg_pic_h);

`ifdef DSC_SLICE_TIMEOUT_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;

    // Counter sits at zero outside WAIT, so every WAIT entry starts fresh.
    assign wd_cnt_d    = (state_q == ST_WAIT) ? wd_cnt_q + 32'd1 : 32'd0;
    assign timeout_hit = (state_q == ST_WAIT) && !slc_done &&
                         (wd_cnt_q == 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) wd_cnt_q <= '0;
        else        wd_cnt_q <= wd_cnt_d;
    end
`else
    // Watchdog compiled out: WAIT never expires.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    load = 1'b1;
                    if (cfg_ok) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort)          state_d = ST_IDLE;
                else if (slc_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (slc_done) begin
                    if (slc_last) begin
                        state_d = ST_DONE;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        slc_valid_d = (state_d == ST_ISSUE);
        cfg_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        frm_done_d  = (state_q == ST_DONE) && !abort;
        err_d       = ((state_q == ST_IDLE) && cfg_valid && !cfg_ok) ||
                      (timeout_hit && !abort);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slc_valid_q <= 1'b0;
            cfg_ready_q <= 1'b1;
            frm_done_q  <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            slc_valid_q <= slc_valid_d;
            cfg_ready_q <= cfg_ready_d;
            frm_done_q  <= frm_done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    dsc_slice_walker #(.DIM_W(DIM_W)) u_walker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .advance    (advance),
        .cfg_pic_w  (cfg_pic_w),
        .cfg_pic_h  (cfg_pic_h),
        .cfg_slice_w(cfg_slice_w),
        .cfg_slice_h(cfg_slice_h),
        .slc_x      (slc_x),
        .slc_y      (slc_y),
        .slc_w      (slc_w),
        .slc_h      (slc_h),
        .slc_last   (slc_last)
    );

    assign slc_valid = slc_valid_q;
    assign cfg_ready = cfg_ready_q;
    assign frm_done  = frm_done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dsc_slice_scheduler.sv
// Randomized bench for dsc_slice_scheduler against a raster-list reference model.
module tb_dsc_slice_scheduler;

    localparam int DIM_W = 13;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int last;
    } slice_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid, cfg_ready;
    logic [DIM_W-1:0] cfg_pic_w, cfg_pic_h, cfg_slice_w, cfg_slice_h;
    logic             abort, slc_valid, slc_ready, slc_last, slc_done;
    logic [DIM_W-1:0] slc_x, slc_y, slc_w, slc_h;
    logic             frm_done, err, busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsc_slice_scheduler #(.DIM_W(DIM_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pic_w(cfg_pic_w), .cfg_pic_h(cfg_pic_h),
        .cfg_slice_w(cfg_slice_w), .cfg_slice_h(cfg_slice_h),
        .abort(abort), .slc_valid(slc_valid), .slc_ready(slc_ready),
        .slc_x(slc_x), .slc_y(slc_y), .slc_w(slc_w), .slc_h(slc_h),
        .slc_last(slc_last), .slc_done(slc_done),
        .frm_done(frm_done), .err(err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: enumerate slices in raster order with plain loops.
    task automatic build_model(input int pw, input int ph, input int sw, input int sh,
                               output slice_t q[$]);
        slice_t s;
        q = {};
        for (int yy = 0; yy < ph; yy += sh) begin
            for (int xx = 0; xx < pw; xx += sw) begin
                s.x = xx;
                s.y = yy;
                s.w = (sw < pw - xx) ? sw : pw - xx;
                s.h = (sh < ph - yy) ? sh : ph - yy;
                s.last = 0;
                q.push_back(s);
            end
        end
        q[q.size()-1].last = 1;
    endtask

    task automatic chk_desc(input string tag, input slice_t s);
        chk({tag, "_valid"}, 32'(slc_valid), 1);
        chk({tag, "_x"},     32'(slc_x), s.x);
        chk({tag, "_y"},     32'(slc_y), s.y);
        chk({tag, "_w"},     32'(slc_w), s.w);
        chk({tag, "_h"},     32'(slc_h), s.h);
        chk({tag, "_last"},  32'(slc_last), s.last);
    endtask

    task automatic send_cfg(input int pw, input int ph, input int sw, input int sh);
        cfg_pic_w   = DIM_W'(pw);
        cfg_pic_h   = DIM_W'(ph);
        cfg_slice_w = DIM_W'(sw);
        cfg_slice_h = DIM_W'(sh);
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic run_frame(input int pw, input int ph, input int sw, input int sh,
                             input int done_dly, input int stall_max);
        slice_t q[$];
        int     stall, d;
        build_model(pw, ph, sw, sh, q);
        send_cfg(pw, ph, sw, sh);
        chk("cfg_busy", 32'(busy), 1);
        chk("cfg_ready_low", 32'(cfg_ready), 0);
        foreach (q[i]) begin
            chk_desc("desc", q[i]);
            stall = $urandom_range(stall_max, 0);
            for (int s = 0; s < stall; s++) begin
                slc_ready = 1'b0;
                slc_done  = 1'($urandom_range(1, 0));
                tick();
                slc_done  = 1'b0;
                chk_desc("stall", q[i]);
            end
            slc_ready = 1'b1;
            tick();
            slc_ready = 1'b0;
            chk("wait_valid", 32'(slc_valid), 0);
            d = (done_dly >= 0) ? done_dly : $urandom_range(4, 0);
            repeat (d) tick();
            slc_done = 1'b1;
            tick();
            slc_done = 1'b0;
            chk("frm_done_early", 32'(frm_done), 0);
        end
        tick();
        chk("frm_done", 32'(frm_done), 1);
        chk("frm_done_ready", 32'(cfg_ready), 1);
        tick();
        chk("frm_done_pulse", 32'(frm_done), 0);
    endtask

    task automatic bad_cfg(input int pw, input int ph, input int sw, input int sh);
        send_cfg(pw, ph, sw, sh);
        chk("bad_err", 32'(err), 1);
        chk("bad_ready", 32'(cfg_ready), 1);
        chk("bad_valid", 32'(slc_valid), 0);
        tick();
        chk("bad_err_pulse", 32'(err), 0);
        chk("bad_valid2", 32'(slc_valid), 0);
    endtask

    // Brings a 1920x1080 / 960x540 frame to WAIT on its second slice.
    task automatic to_second_wait();
        send_cfg(1920, 1080, 960, 540);
        slc_ready = 1'b1;
        tick();
        slc_ready = 1'b0;
        slc_done  = 1'b1;
        tick();
        slc_done  = 1'b0;
        chk("second_x", 32'(slc_x), 960);
        slc_ready = 1'b1;
        tick();
        slc_ready = 1'b0;
    endtask

    initial begin
        int pw, ph, sw, sh, errs;
        rst_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; slc_ready = 1'b0; slc_done = 1'b0;
        cfg_pic_w = '0; cfg_pic_h = '0; cfg_slice_w = '0; cfg_slice_h = '0;
        tick(); tick();
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(slc_valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_frm_done", 32'(frm_done), 0);
        chk("rst_x", 32'(slc_x), 0);
        rst_n = 1'b1;
        tick();

        run_frame(1920, 1080, 960, 540, 9, 0);
        run_frame(1000, 100, 384, 64, -1, 2);
        run_frame(7, 5, 7, 5, -1, 5);
        bad_cfg(1920, 1080, 0, 540);
        bad_cfg(1920, 1080, 2000, 540);
        bad_cfg(0, 10, 1, 1);

        for (int f = 0; f < 12; f++) begin
            pw = $urandom_range(24, 1);
            ph = $urandom_range(24, 1);
            sw = $urandom_range(pw, 1);
            sh = $urandom_range(ph, 1);
            if ($urandom_range(3, 0) == 0) begin
                if ($urandom_range(1, 0) == 1) bad_cfg(pw, ph, pw + $urandom_range(5, 1), sh);
                else                           bad_cfg(pw, ph, sw, 0);
            end else begin
                run_frame(pw, ph, sw, sh, -1, 5);
            end
        end

        // Abort wins over a simultaneous slc_done on slice 2 of 4.
        to_second_wait();
        abort    = 1'b1;
        slc_done = 1'b1;
        tick();
        abort    = 1'b0;
        slc_done = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_ready", 32'(cfg_ready), 1);
        chk("abort_valid", 32'(slc_valid), 0);
        chk("abort_frm_done", 32'(frm_done), 0);
        repeat (3) begin
            tick();
            chk("abort_no_frm_done", 32'(frm_done), 0);
        end

        // Reset in the middle of WAIT.
        to_second_wait();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_ready", 32'(cfg_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(slc_valid), 0);
        chk("mid_rst_x", 32'(slc_x), 0);
        chk("mid_rst_w", 32'(slc_w), 0);
        chk("mid_rst_last", 32'(slc_last), 0);
        rst_n = 1'b1;
        tick();
        run_frame(12, 8, 5, 3, -1, 2);

        // slc_done withheld in WAIT.
        send_cfg(8, 8, 4, 4);
        slc_ready = 1'b1;
        tick();
        slc_ready = 1'b0;
`ifdef DSC_SLICE_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("wd_err", 32'(err), (k == 16) ? 1 : 0);
        end
        chk("wd_idle", 32'(cfg_ready), 1);
        chk("wd_no_frm_done", 32'(frm_done), 0);
        tick();
        chk("wd_err_pulse", 32'(err), 0);
`else
        errs = 0;
        repeat (1000) begin
            tick();
            if (err) errs++;
        end
        chk("nowd_err_count", 32'(errs), 0);
        chk("nowd_busy", 32'(busy), 1);
        chk("nowd_valid", 32'(slc_valid), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("nowd_abort_idle", 32'(cfg_ready), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
